// File: rtl/magnetron_ctrl_power_pkg.sv
// ============================================================================
// Module      : magnetron_ctrl_power_pkg
// Description : Shared cook-state encodings and default duty-cycle period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package magnetron_ctrl_power_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C_DEFAULT_PERIOD = 10;

endpackage

`default_nettype wire

// File: rtl/magnetron_ctrl_power_duty_slot_gen.sv
// ============================================================================
// Module      : duty_slot_gen
// Description : Duty-slot counter; reports whether the upcoming slot is an
//               "on" slot for the captured power level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import magnetron_ctrl_power_pkg::*;

module duty_slot_gen #(
    parameter int PERIOD  = C_DEFAULT_PERIOD,
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               advance,
    input  logic [LEVEL_W-1:0] lvl,
    output logic               slot_on
);

    localparam int C_SW = $clog2(PERIOD);

    logic [C_SW-1:0] r_slot;
    logic [C_SW-1:0] w_slot_next;

    always_comb begin
        w_slot_next = r_slot;
        if (restart) begin
            w_slot_next = '0;
        end else if (advance) begin
            w_slot_next = (r_slot == C_SW'(PERIOD - 1)) ? '0 : r_slot + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    // Compare against the next slot so the registered enable lines up with it.
    assign slot_on = (LEVEL_W'(w_slot_next) < lvl);

endmodule

`default_nettype wire

// File: rtl/magnetron_ctrl_power.sv
// ============================================================================
// Module      : magnetron_ctrl_power
// Description : Cook FSM with edge-detected buttons, duty-cycled power level
//               and door interlock. Optional done buzzer via DONE_BEEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import magnetron_ctrl_power_pkg::*;

module magnetron_ctrl_power #(
    parameter int PERIOD     = C_DEFAULT_PERIOD,
    parameter int LEVEL_W    = 4,
    parameter int BEEP_TICKS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    input  logic               timer_done,
    input  logic [LEVEL_W-1:0] power_level,
    output logic               mag_on,
    output logic [1:0]         state,
    output logic               buzzer
);

    localparam logic [LEVEL_W-1:0] C_PERIOD = LEVEL_W'(PERIOD);

    // Illegal parameter sets leave this block elaborated as a visible marker.
    if (PERIOD < 2 || BEEP_TICKS < 1 || (2 ** LEVEL_W) <= PERIOD) begin : g_param_error
    end

    state_t             r_state;
    state_t             w_next;
    logic               r_startn_q, r_stopn_q, r_clearn_q;
    logic               r_mag_q;
    logic [LEVEL_W-1:0] r_lvl;
    logic               w_press_start, w_press_stop, w_press_clear;
    logic               w_can_start, w_enter_cook, w_advance, w_slot_on;
    logic [LEVEL_W-1:0] w_lvl_cap, w_lvl_next;

    assign w_press_start = r_startn_q & ~startn;
    assign w_press_stop  = r_stopn_q  & ~stopn;
    assign w_press_clear = r_clearn_q & ~clearn;
    assign w_can_start   = w_press_start & door_closed & ~timer_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_can_start) w_next = ST_COOK;
            ST_COOK: begin
                if (timer_done)                        w_next = ST_DONE;
                else if (!door_closed)                 w_next = ST_PAUSE;
                else if (w_press_stop || w_press_clear) w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_press_clear)    w_next = ST_IDLE;
                else if (w_can_start) w_next = ST_COOK;
            end
            ST_DONE:  if (w_press_clear) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_enter_cook = (w_next == ST_COOK) && (r_state != ST_COOK);
    assign w_lvl_cap    = (power_level > C_PERIOD) ? C_PERIOD : power_level;
    assign w_lvl_next   = w_enter_cook ? w_lvl_cap : r_lvl;
    assign w_advance    = tick & (r_state == ST_COOK);

    duty_slot_gen #(
        .PERIOD  (PERIOD),
        .LEVEL_W (LEVEL_W)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .restart (w_enter_cook),
        .advance (w_advance),
        .lvl     (w_lvl_next),
        .slot_on (w_slot_on)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lvl      <= '0;
            r_mag_q    <= 1'b0;
            r_startn_q <= 1'b1;
            r_stopn_q  <= 1'b1;
            r_clearn_q <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_lvl      <= w_lvl_next;
            r_mag_q    <= (w_next == ST_COOK) & w_slot_on;
            r_startn_q <= startn;
            r_stopn_q  <= stopn;
            r_clearn_q <= clearn;
        end
    end

    // Door gate is combinational so an opened door cuts power immediately.
    assign mag_on = r_mag_q & door_closed;
    assign state  = r_state;

`ifdef DONE_BEEP_EN
    localparam int C_BW = $clog2(BEEP_TICKS + 1);

    logic            r_buzzer;
    logic [C_BW-1:0] r_beep_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buzzer   <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_next != ST_DONE) begin
            r_buzzer   <= 1'b0;
        end else if (r_state != ST_DONE) begin
            r_buzzer   <= 1'b1;
            r_beep_cnt <= '0;
        end else if (tick && r_buzzer) begin
            if (r_beep_cnt == C_BW'(BEEP_TICKS - 1)) r_buzzer <= 1'b0;
            r_beep_cnt <= r_beep_cnt + 1'b1;
        end
    end

    assign buzzer = r_buzzer;
`else
    assign buzzer = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_magnetron_ctrl_power.sv
// ============================================================================
// Module      : tb_magnetron_ctrl_power
// Description : Self-checking bench: directed scenarios plus randomized run
//               against a behavioural model of the cook controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magnetron_ctrl_power;

    localparam int PERIOD     = 10;
    localparam int LEVEL_W    = 4;
    localparam int BEEP_TICKS = 3;
    localparam int IDLE = 0, COOK = 1, PAUSE = 2, DONE = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               tick = 1'b0;
    logic               startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic               door_closed = 1'b1;
    logic               timer_done = 1'b0;
    logic [LEVEL_W-1:0] power_level = '0;
    logic               mag_on;
    logic [1:0]         state;
    logic               buzzer;

    int vectors = 0;
    int miscompares = 0;

    magnetron_ctrl_power #(
        .PERIOD     (PERIOD),
        .LEVEL_W    (LEVEL_W),
        .BEEP_TICKS (BEEP_TICKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .power_level (power_level),
        .mag_on      (mag_on),
        .state       (state),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    // Behavioural reference model, advanced on every rising edge.
    int m_state = IDLE, m_slot = 0, m_lvl = 0, m_beep_left = 0;
    bit m_mag = 0, m_buzz = 0;
    bit m_ps = 1, m_pp = 1, m_pc = 1;

    always @(posedge clk) begin : model
        int  ns;
        bit  ev_start, ev_stop, ev_clear, ok_start;
        if (rst) begin
            m_state = IDLE; m_slot = 0; m_lvl = 0; m_mag = 0; m_buzz = 0;
            m_ps = 1; m_pp = 1; m_pc = 1;
        end else begin
            ev_start = m_ps && !startn;
            ev_stop  = m_pp && !stopn;
            ev_clear = m_pc && !clearn;
            ok_start = ev_start && door_closed && !timer_done;
            ns = m_state;
            if (m_state == IDLE && ok_start) ns = COOK;
            else if (m_state == COOK && (timer_done)) ns = DONE;
            else if (m_state == COOK && (!door_closed || ev_stop || ev_clear)) ns = PAUSE;
            else if (m_state == PAUSE && ev_clear) ns = IDLE;
            else if (m_state == PAUSE && ok_start) ns = COOK;
            else if (m_state == DONE && ev_clear) ns = IDLE;
            if (ns == COOK && m_state != COOK) begin
                m_slot = 0;
                m_lvl  = (int'(power_level) > PERIOD) ? PERIOD : int'(power_level);
            end else if (m_state == COOK && tick) begin
                m_slot = (m_slot + 1) % PERIOD;
            end
            m_mag = (ns == COOK) && (m_slot < m_lvl);
            if (ns != DONE) m_buzz = 0;
            else if (m_state != DONE) begin m_buzz = 1; m_beep_left = BEEP_TICKS; end
            else if (tick && m_buzz) begin
                m_beep_left--;
                if (m_beep_left == 0) m_buzz = 0;
            end
`ifndef DONE_BEEP_EN
            m_buzz = 0;
`endif
            m_ps = startn; m_pp = stopn; m_pc = clearn;
            m_state = ns;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_idle();
        startn = 1; stopn = 1; clearn = 1; tick = 0; timer_done = 0; door_closed = 1;
        rst = 1; cyc(1); rst = 0;
    endtask

    task automatic go_cook(input int lvl);
        to_idle();
        power_level = LEVEL_W'(lvl);
        startn = 0; cyc(1); startn = 1;
    endtask

    task automatic test_reset();
        rst = 1; cyc(3); rst = 0;
        vectors++;
        if (state !== 2'(IDLE) || mag_on !== 1'b0 || buzzer !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: state=%0d mag_on=%b buzzer=%b, required 0/0/0", state, mag_on, buzzer);
        end
        cyc(1);
        vectors++;
        if (state !== 2'(IDLE)) begin
            miscompares++;
            $display("FAIL reset_hold: state=%0d, required %0d", state, IDLE);
        end
    endtask

    task automatic test_start_interlock();
        to_idle();
        power_level = 4'd4;
        door_closed = 0; startn = 0; cyc(1); startn = 1; cyc(1);
        vectors++;
        if (state !== 2'(IDLE) || mag_on !== 1'b0) begin
            miscompares++;
            $display("FAIL start_door_open: state=%0d mag_on=%b, required %0d/0", state, mag_on, IDLE);
        end
        door_closed = 1; startn = 0; cyc(1); startn = 1;
        vectors++;
        if (state !== 2'(COOK) || mag_on !== 1'b1) begin
            miscompares++;
            $display("FAIL start_door_closed: state=%0d mag_on=%b, required %0d/1", state, mag_on, COOK);
        end
    endtask

    task automatic test_duty(input int lvl);
        int eff, bad;
        eff = (lvl > PERIOD) ? PERIOD : lvl;
        bad = 0;
        go_cook(lvl);
        for (int t = 0; t < 2 * PERIOD; t++) begin
            if (mag_on !== ((t % PERIOD) < eff)) begin
                bad++;
                $display("FAIL duty_lvl%0d slot %0d: mag_on=%b, required %b", lvl, t % PERIOD, mag_on, (t % PERIOD) < eff);
            end
            // power level changes inside COOK must be ignored
            power_level = LEVEL_W'($urandom_range(0, 15));
            tick = 1; cyc(1); tick = 0; cyc(1);
        end
        vectors++;
        if (bad != 0) miscompares++;
    endtask

    task automatic test_door();
        go_cook(4);
        repeat (5) begin tick = 1; cyc(1); tick = 0; end
        door_closed = 1; #1;
        vectors++;
        if (mag_on !== 1'b0) begin
            miscompares++;
            $display("FAIL door_slot5: mag_on=%b, required 0", mag_on);
        end
        repeat (5) begin tick = 1; cyc(1); tick = 0; end
        vectors++;
        if (mag_on !== 1'b1) begin
            miscompares++;
            $display("FAIL door_wrap: mag_on=%b, required 1", mag_on);
        end
        door_closed = 0; #1;
        vectors++;
        if (mag_on !== 1'b0) begin
            miscompares++;
            $display("FAIL door_gate: mag_on=%b, required 0", mag_on);
        end
        cyc(1);
        vectors++;
        if (state !== 2'(PAUSE)) begin
            miscompares++;
            $display("FAIL door_pause: state=%0d, required %0d", state, PAUSE);
        end
        door_closed = 1; tick = 1; cyc(1); tick = 1; cyc(1); tick = 0;
        startn = 0; cyc(1); startn = 1;
        vectors++;
        if (state !== 2'(COOK) || mag_on !== 1'b1) begin
            miscompares++;
            $display("FAIL door_resume: state=%0d mag_on=%b, required %0d/1", state, mag_on, COOK);
        end
        repeat (4) begin tick = 1; cyc(1); tick = 0; end
        vectors++;
        if (mag_on !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_slot4: mag_on=%b, required 0", mag_on);
        end
    endtask

    task automatic test_priority();
        go_cook(4);
        timer_done = 1; stopn = 0; cyc(1); timer_done = 0; stopn = 1;
        vectors++;
        if (state !== 2'(DONE) || mag_on !== 1'b0) begin
            miscompares++;
            $display("FAIL done_priority: state=%0d mag_on=%b, required %0d/0", state, mag_on, DONE);
        end
        startn = 0; cyc(1); startn = 1;
        vectors++;
        if (state !== 2'(DONE)) begin
            miscompares++;
            $display("FAIL done_ignore_start: state=%0d, required %0d", state, DONE);
        end
        clearn = 0; cyc(1); clearn = 1;
        vectors++;
        if (state !== 2'(IDLE)) begin
            miscompares++;
            $display("FAIL done_clear: state=%0d, required %0d", state, IDLE);
        end
    endtask

    task automatic test_held();
        int transitions;
        logic [1:0] prev;
        go_cook(5);
        stopn = 0; cyc(1); stopn = 1;
        vectors++;
        if (state !== 2'(PAUSE)) begin
            miscompares++;
            $display("FAIL held_pause: state=%0d, required %0d", state, PAUSE);
        end
        transitions = 0; prev = state;
        clearn = 0; startn = 0; cyc(1); clearn = 1;
        for (int i = 0; i < 50; i++) begin
            if (state !== prev) transitions++;
            prev = state;
            cyc(1);
        end
        vectors++;
        if (transitions != 1 || state !== 2'(IDLE)) begin
            miscompares++;
            $display("FAIL held_start: transitions=%0d state=%0d, required 1/%0d", transitions, state, IDLE);
        end
        startn = 1; cyc(1); startn = 0; cyc(1); startn = 1;
        vectors++;
        if (state !== 2'(COOK)) begin
            miscompares++;
            $display("FAIL fresh_edge: state=%0d, required %0d", state, COOK);
        end
    endtask

    task automatic test_rst_mid();
        go_cook(10);
        repeat (3) begin tick = 1; cyc(1); tick = 0; end
        rst = 1; cyc(1); rst = 0;
        vectors++;
        if (mag_on !== 1'b0 || state !== 2'(IDLE)) begin
            miscompares++;
            $display("FAIL rst_mid_cook: mag_on=%b state=%0d, required 0/%0d", mag_on, state, IDLE);
        end
    endtask

`ifdef DONE_BEEP_EN
    task automatic test_beep();
        int bad;
        bad = 0;
        go_cook(4);
        timer_done = 1; cyc(1); timer_done = 0;
        if (buzzer !== 1'b1) bad++;
        for (int i = 0; i < 5; i++) begin
            cyc(2);
            tick = 1; cyc(1); tick = 0;
            if (buzzer !== (i < BEEP_TICKS - 1)) begin
                bad++;
                $display("FAIL beep tick %0d: buzzer=%b, required %b", i + 1, buzzer, i < BEEP_TICKS - 1);
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
    endtask
`endif

    task automatic test_random();
        int bad;
        bad = 0;
        to_idle();
        for (int i = 0; i < 3000; i++) begin
            if (state !== 2'(m_state) || mag_on !== (m_mag & door_closed) || buzzer !== m_buzz) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random cyc %0d: state=%0d mag_on=%b buzzer=%b, required %0d/%b/%b",
                             i, state, mag_on, buzzer, m_state, m_mag & door_closed, m_buzz);
            end
            vectors++;
            rst         = ($urandom_range(0, 299) == 0);
            tick        = ($urandom_range(0, 2) == 0);
            startn      = ($urandom_range(0, 3) != 0);
            stopn       = ($urandom_range(0, 15) != 0);
            clearn      = ($urandom_range(0, 19) != 0);
            door_closed = ($urandom_range(0, 11) != 0);
            timer_done  = ($urandom_range(0, 39) == 0);
            power_level = LEVEL_W'($urandom_range(0, 15));
            cyc(1);
        end
        rst = 0;
        if (bad != 0) miscompares += bad;
    endtask

    initial begin
        test_reset();
        test_start_interlock();
        test_duty(4);
        test_duty(0);
        test_duty(15);
        test_duty(7);
        test_door();
        test_priority();
        test_held();
        test_rst_mid();
`ifdef DONE_BEEP_EN
        test_beep();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
